// File: rtl/ev_timer_pkg.sv
// Shared types for the ID-tagged event latency tracker.
// Record layouts depend on ID_W/TS_W, so each user builds its own record struct from status_e.
package ev_timer_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    StatusOk        = 2'd0,
    StatusTimeout   = 2'd1,
    StatusOrphanEnd = 2'd2,
    StatusDupStart  = 2'd3
  } status_e;

endpackage

// File: rtl/ev_rec_fifo.sv
// Synchronous record FIFO.
// Entries live in flops and the head entry drives the outputs directly.
module ev_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  always_comb begin
    o_full  = (r_count == DEPTH_CNT);
    o_empty = (r_count == '0);
    w_do_rd = i_rd && !o_empty;
    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
    w_do_wr = i_wr && (!o_full || w_do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/ev_latency_tracker.sv
// ID-tagged start/end latency tracker with timeout sweep and error records.
// One record per cycle at most; priority end > duplicate start > timeout.
module ev_latency_tracker
  import ev_timer_pkg::*;
#(
  parameter int unsigned ID_W       = 3,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [ID_W-1:0] start_id,
  input  logic            end_valid,
  output logic            end_ready,
  input  logic [ID_W-1:0] end_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic [TS_W-1:0] out_start_ts,
  output logic [TS_W-1:0] out_end_ts,
  output logic [TS_W-1:0] out_delta,
  output logic [1:0]      out_status,
  output logic [ID_W:0]   active_cnt
);

  localparam int unsigned NUM_IDS = 2 ** ID_W;
  localparam logic [TS_W-1:0] TIMEOUT_TS = TS_W'(TIMEOUT);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
    status_e         status;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

  logic [TS_W-1:0]    r_cnt;
  logic [NUM_IDS-1:0] r_active;
  logic [TS_W-1:0]    r_stamp [NUM_IDS];
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W:0]      r_active_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_end_fire;
  logic            w_start_fire;
  logic            w_start_dup;
  logic [TS_W-1:0] w_sweep_age;
  logic            w_sweep_expired;
  logic            w_sweep_touched;
  logic            w_timeout_fire;
  logic            w_arm_new;
  logic            w_clear;
  logic            w_wr;
  rec_t            w_rec;
  rec_t            w_rd_rec;

  always_comb begin
    end_ready    = !w_full;
    w_end_fire   = end_valid && !w_full;
    // A start that would need its own record (dup) or collides with the ending ID waits a cycle.
    start_ready  = !w_full && !(w_end_fire && ((start_id == end_id) || r_active[start_id]));
    w_start_fire = start_valid && start_ready;
    w_start_dup  = w_start_fire && r_active[start_id];

    w_sweep_age     = r_cnt - r_stamp[r_ptr];
    w_sweep_expired = (TIMEOUT != 0) && r_active[r_ptr] && (w_sweep_age >= TIMEOUT_TS);
    w_sweep_touched = (w_start_fire && (start_id == r_ptr)) || (w_end_fire && (end_id == r_ptr));
    w_timeout_fire  = w_sweep_expired && !w_end_fire && !w_start_dup && !w_full &&
                      !w_sweep_touched;

    w_arm_new = w_start_fire && !r_active[start_id];
    w_clear   = (w_end_fire && r_active[end_id]) || w_timeout_fire;
  end

  always_comb begin
    w_wr  = 1'b0;
    w_rec = '0;
    if (w_end_fire) begin
      w_wr         = 1'b1;
      w_rec.id     = end_id;
      w_rec.end_ts = r_cnt;
      if (r_active[end_id]) begin
        w_rec.start_ts = r_stamp[end_id];
        w_rec.delta    = r_cnt - r_stamp[end_id];
        w_rec.status   = StatusOk;
      end else begin
        w_rec.status = StatusOrphanEnd;
      end
    end else if (w_start_dup) begin
      w_wr           = 1'b1;
      w_rec.id       = start_id;
      w_rec.start_ts = r_stamp[start_id];
      w_rec.end_ts   = r_cnt;
      w_rec.delta    = r_cnt - r_stamp[start_id];
      w_rec.status   = StatusDupStart;
    end else if (w_timeout_fire) begin
      w_wr           = 1'b1;
      w_rec.id       = r_ptr;
      w_rec.start_ts = r_stamp[r_ptr];
      w_rec.end_ts   = r_cnt;
      w_rec.delta    = w_sweep_age;
      w_rec.status   = StatusTimeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_active     <= '0;
      r_ptr        <= '0;
      r_active_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TS_W'(1);
      if (w_end_fire) begin
        r_active[end_id] <= 1'b0;
      end
      if (w_timeout_fire) begin
        r_active[r_ptr] <= 1'b0;
      end
      // Start never targets the ending or timed-out ID in the same cycle, so no overlap here.
      if (w_start_fire) begin
        r_active[start_id] <= 1'b1;
      end
      if (!(w_sweep_expired && !w_timeout_fire)) begin
        r_ptr <= r_ptr + ID_W'(1);
      end
      case ({w_arm_new, w_clear})
        2'b10:   r_active_cnt <= r_active_cnt + (ID_W + 1)'(1);
        2'b01:   r_active_cnt <= r_active_cnt - (ID_W + 1)'(1);
        default: r_active_cnt <= r_active_cnt;
      endcase
    end
  end

  // Stamp RAM needs no reset: entries are only read while their active bit is set.
  always_ff @(posedge clk) begin
    if (w_start_fire) begin
      r_stamp[start_id] <= r_cnt;
    end
  end

  ev_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rec_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr),
    .i_wr_data (w_rec),
    .i_rd      (out_ready),
    .o_rd_data (w_rd_rec),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    out_valid    = !w_empty;
    out_id       = w_rd_rec.id;
    out_start_ts = w_rd_rec.start_ts;
    out_end_ts   = w_rd_rec.end_ts;
    out_delta    = w_rd_rec.delta;
    out_status   = w_rd_rec.status;
    active_cnt   = r_active_cnt;
  end

endmodule

// File: tb/tb_ev_latency_tracker.sv
// Bench for ev_latency_tracker: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a narrow-counter instance for wrap and reset.
module tb_ev_latency_tracker;

  localparam int NID   = 8;
  localparam int DEPTH = 4;
  localparam int TO_A  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, a_sv, a_ev, a_or, a_sr, a_er, a_ov;
  logic [2:0]  a_sid, a_eid, a_oid;
  logic [15:0] a_ost, a_oet, a_odl;
  logic [1:0]  a_ostat;
  logic [3:0]  a_ac;

  logic        rst_b, b_sv, b_ev, b_or, b_sr, b_er, b_ov;
  logic [2:0]  b_sid, b_eid, b_oid;
  logic [7:0]  b_ost, b_oet, b_odl;
  logic [1:0]  b_ostat;
  logic [3:0]  b_ac;

  ev_latency_tracker #(.ID_W(3), .TS_W(16), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst_a),
    .start_valid(a_sv), .start_ready(a_sr), .start_id(a_sid),
    .end_valid(a_ev), .end_ready(a_er), .end_id(a_eid),
    .out_valid(a_ov), .out_ready(a_or), .out_id(a_oid), .out_start_ts(a_ost),
    .out_end_ts(a_oet), .out_delta(a_odl), .out_status(a_ostat), .active_cnt(a_ac)
  );

  ev_latency_tracker #(.ID_W(3), .TS_W(8), .FIFO_DEPTH(DEPTH), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst_b),
    .start_valid(b_sv), .start_ready(b_sr), .start_id(b_sid),
    .end_valid(b_ev), .end_ready(b_er), .end_id(b_eid),
    .out_valid(b_ov), .out_ready(b_or), .out_id(b_oid), .out_start_ts(b_ost),
    .out_end_ts(b_oet), .out_delta(b_odl), .out_status(b_ostat), .active_cnt(b_ac)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int st;
    int et;
    int dl;
    int s;
  } mrec_t;

  mrec_t m_q[$];
  bit    m_act[NID];
  int    m_stamp[NID];
  int    m_cnt;
  int    m_ptr;
  int    b_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int m_active_cnt();
    int s = 0;
    for (int i = 0; i < NID; i++) s += int'(m_act[i]);
    return s;
  endfunction

  function automatic bit m_full();
    return m_q.size() == DEPTH;
  endfunction

  function automatic bit m_end_fire();
    return a_ev && !m_full();
  endfunction

  function automatic bit m_start_ready();
    return !m_full() && !(m_end_fire() && ((a_sid == a_eid) || m_act[a_sid]));
  endfunction

  // Applies one clock edge of the specified behaviour to the model, using pre-edge values.
  task automatic model_step();
    bit    full, ef, sf, dup, expd, tch, tof, pop, wr;
    int    age, p;
    mrec_t r;
    if (rst_a) begin
      m_q.delete();
      for (int i = 0; i < NID; i++) m_act[i] = 1'b0;
      m_cnt = 0;
      m_ptr = 0;
      return;
    end
    full = m_full();
    ef   = m_end_fire();
    sf   = a_sv && m_start_ready();
    dup  = sf && m_act[a_sid];
    p    = m_ptr;
    age  = (m_cnt - m_stamp[p]) & 'hFFFF;
    expd = m_act[p] && (age >= TO_A);
    tch  = (sf && (int'(a_sid) == p)) || (ef && (int'(a_eid) == p));
    tof  = expd && !ef && !dup && !full && !tch;
    pop  = a_or && (m_q.size() > 0);
    wr   = 1'b0;
    r    = '{0, 0, 0, 0, 0};
    if (ef) begin
      wr = 1'b1;
      if (m_act[a_eid]) begin
        r = '{int'(a_eid), m_stamp[a_eid], m_cnt, (m_cnt - m_stamp[a_eid]) & 'hFFFF, 0};
        m_act[a_eid] = 1'b0;
      end else begin
        r = '{int'(a_eid), 0, m_cnt, 0, 2};
      end
    end else if (dup) begin
      wr = 1'b1;
      r  = '{int'(a_sid), m_stamp[a_sid], m_cnt, (m_cnt - m_stamp[a_sid]) & 'hFFFF, 3};
    end else if (tof) begin
      wr = 1'b1;
      r  = '{p, m_stamp[p], m_cnt, age, 1};
      m_act[p] = 1'b0;
    end
    if (sf) begin
      m_act[a_sid]   = 1'b1;
      m_stamp[a_sid] = m_cnt;
    end
    if (!(expd && !tof)) m_ptr = (m_ptr + 1) % NID;
    if (pop) void'(m_q.pop_front());
    if (wr) m_q.push_back(r);
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  // One clock: check readiness, advance the model at the edge, compare outputs mid-cycle.
  task automatic cycle();
    #1;
    if (!rst_a) begin
      chk("end_ready", 32'(a_er), 32'(!m_full()));
      chk("start_ready", 32'(a_sr), 32'(m_start_ready()));
    end
    @(posedge clk);
    model_step();
    b_cnt = rst_b ? 0 : (b_cnt + 1) % 256;
    @(negedge clk);
    chk("out_valid", 32'(a_ov), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_id", 32'(a_oid), m_q[0].id);
      chk("out_start_ts", 32'(a_ost), m_q[0].st);
      chk("out_end_ts", 32'(a_oet), m_q[0].et);
      chk("out_delta", 32'(a_odl), m_q[0].dl);
      chk("out_status", 32'(a_ostat), m_q[0].s);
    end
    chk("active_cnt", 32'(a_ac), m_active_cnt());
  endtask

  task automatic wait_cnt(input int t);
    int n = 0;
    while (m_cnt != t && n < 300) begin
      cycle();
      n++;
    end
    if (m_cnt != t) bound_fail("wait_cnt");
  endtask

  task automatic wait_b(input int t);
    int n = 0;
    while (b_cnt != t && n < 300) begin
      cycle();
      n++;
    end
    if (b_cnt != t) bound_fail("wait_b");
  endtask

  task automatic chk_rec_a(input string tag, input int id, input int st, input int et,
                           input int dl, input int s);
    chk({tag, "_id"}, 32'(a_oid), id);
    chk({tag, "_start"}, 32'(a_ost), st);
    chk({tag, "_end"}, 32'(a_oet), et);
    chk({tag, "_delta"}, 32'(a_odl), dl);
    chk({tag, "_status"}, 32'(a_ostat), s);
  endtask

  initial begin
    bit seen;
    rst_a = 1'b1; a_sv = 1'b0; a_ev = 1'b0; a_or = 1'b1; a_sid = '0; a_eid = '0;
    rst_b = 1'b1; b_sv = 1'b0; b_ev = 1'b0; b_or = 1'b1; b_sid = '0; b_eid = '0;
    b_cnt = 0;
    cycle();
    cycle();
    chk("rst_out_valid", 32'(a_ov), 0);
    chk("rst_out_id", 32'(a_oid), 0);
    chk("rst_out_start", 32'(a_ost), 0);
    chk("rst_out_delta", 32'(a_odl), 0);
    chk("rst_active_cnt", 32'(a_ac), 0);
    chk("rst_b_out_valid", 32'(b_ov), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Basic start/end pair
    wait_cnt(10);
    a_sv = 1'b1; a_sid = 3'd3;
    cycle();
    a_sv = 1'b0;
    chk("t1_active_1", 32'(a_ac), 1);
    wait_cnt(16);
    a_ev = 1'b1; a_eid = 3'd3;
    cycle();
    a_ev = 1'b0;
    chk_rec_a("t1", 3, 10, 16, 6, 0);
    chk("t1_active_0", 32'(a_ac), 0);

    // Same-ID start/end collision: end wins, start lands a cycle later
    wait_cnt(30);
    a_sv = 1'b1; a_sid = 3'd5;
    cycle();
    a_sv = 1'b0;
    wait_cnt(35);
    a_sv = 1'b1; a_sid = 3'd5; a_ev = 1'b1; a_eid = 3'd5;
    #1 chk("t3_start_blocked", 32'(a_sr), 0);
    cycle();
    a_ev = 1'b0;
    chk_rec_a("t3a", 5, 30, 35, 5, 0);
    cycle();
    a_sv = 1'b0;
    chk("t3_rearmed", 32'(a_ac), 1);
    wait_cnt(40);
    a_ev = 1'b1; a_eid = 3'd5;
    cycle();
    a_ev = 1'b0;
    chk_rec_a("t3b", 5, 36, 40, 4, 0);

    // Duplicate start
    wait_cnt(50);
    a_sv = 1'b1; a_sid = 3'd1;
    cycle();
    a_sv = 1'b0;
    wait_cnt(55);
    a_sv = 1'b1; a_sid = 3'd1;
    cycle();
    a_sv = 1'b0;
    chk_rec_a("t5a", 1, 50, 55, 5, 3);
    wait_cnt(60);
    a_ev = 1'b1; a_eid = 3'd1;
    cycle();
    a_ev = 1'b0;
    chk_rec_a("t5b", 1, 55, 60, 5, 0);

    // Timeout, then a late end is an orphan
    wait_cnt(100);
    a_sv = 1'b1; a_sid = 3'd2;
    cycle();
    a_sv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = a_ov;
    end
    if (!seen) bound_fail("t4_timeout_record");
    chk("t4_status", 32'(a_ostat), 1);
    chk("t4_id", 32'(a_oid), 2);
    chk("t4_start", 32'(a_ost), 100);
    chk("t4_end_in_window", 32'(a_oet >= 16'd120 && a_oet <= 16'd127), 1);
    chk("t4_delta_ge_to", 32'(a_odl >= 16'd20), 1);
    cycle();
    a_ev = 1'b1; a_eid = 3'd2;
    cycle();
    a_ev = 1'b0;
    chk("t4_orphan_status", 32'(a_ostat), 2);
    chk("t4_orphan_start", 32'(a_ost), 0);
    chk("t4_orphan_delta", 32'(a_odl), 0);

    // Backpressure: FIFO fills, end stalls, drain preserves order
    cycle();
    a_or = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_sv = 1'b1; a_sid = 3'(i);
      cycle();
    end
    a_sv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ev = 1'b1; a_eid = 3'(i);
      cycle();
    end
    a_eid = 3'd4;
    #1 chk("t2_end_stalled", 32'(a_er), 0);
    chk("t2_head_id0", 32'(a_oid), 0);
    cycle();
    a_or = 1'b1;
    cycle();
    chk("t2_head_id1", 32'(a_oid), 1);
    cycle();
    a_ev = 1'b0;
    chk("t2_head_id2", 32'(a_oid), 2);
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_drained", 32'(a_ov), 0);

    // Narrow counter: wrap-around delta, then reset with records and IDs in flight
    wait_b(250);
    b_sv = 1'b1; b_sid = 3'd0;
    cycle();
    b_sv = 1'b0;
    wait_b(4);
    b_ev = 1'b1; b_eid = 3'd0;
    cycle();
    b_ev = 1'b0;
    chk("t6_start", 32'(b_ost), 250);
    chk("t6_end", 32'(b_oet), 4);
    chk("t6_delta", 32'(b_odl), 10);
    chk("t6_status", 32'(b_ostat), 0);
    cycle();
    b_or = 1'b0;
    b_sv = 1'b1; b_sid = 3'd1;
    cycle();
    b_sid = 3'd2;
    cycle();
    b_sv = 1'b0;
    b_ev = 1'b1; b_eid = 3'd6;
    cycle();
    b_ev = 1'b0;
    chk("t6_queued", 32'(b_ov), 1);
    chk("t6_active2", 32'(b_ac), 2);
    rst_b = 1'b1;
    cycle();
    rst_b = 1'b0;
    chk("t6_rst_valid", 32'(b_ov), 0);
    chk("t6_rst_active", 32'(b_ac), 0);
    chk("t6_rst_end_ready", 32'(b_er), 1);
    b_or = 1'b1;
    b_ev = 1'b1; b_eid = 3'd1;
    cycle();
    b_ev = 1'b0;
    chk("t6_orphan_id", 32'(b_oid), 1);
    chk("t6_orphan_status", 32'(b_ostat), 2);
    chk("t6_orphan_start", 32'(b_ost), 0);
    chk("t6_orphan_delta", 32'(b_odl), 0);

    // Randomised traffic with backpressure phases and rare resets
    for (int i = 0; i < 2500; i++) begin
      a_sv  = ($urandom_range(0, 99) < 30);
      a_sid = 3'($urandom_range(0, 7));
      a_ev  = ($urandom_range(0, 99) < 20);
      a_eid = 3'($urandom_range(0, 7));
      a_or  = ((i % 400) < 100) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 80);
      rst_a = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst_a = 1'b0;
    a_sv  = 1'b0;
    a_ev  = 1'b0;
    a_or  = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
